// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - host and SPI pin bundle for spi_master_ctrl
// lsb_first exists only when SPI_MASTER_LSB_FIRST_EN is defined.
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 3
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [CS_W-1:0]   cs_sel;
  logic              cpol;
  logic              cpha;
  logic              miso;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic              lsb_first;
`endif
  logic              sclk;
  logic              mosi;
  logic [NUM_CS-1:0] cs_n;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;

  modport master (
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  lsb_first,
`endif
    input  start, tx_data, cs_sel, cpol, cpha, miso,
    output sclk, mosi, cs_n, rx_data, busy, done
  );

  modport slave (
`ifdef SPI_MASTER_LSB_FIRST_EN
    output lsb_first,
`endif
    output start, tx_data, cs_sel, cpol, cpha, miso,
    input  sclk, mosi, cs_n, rx_data, busy, done
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master, fixed SCLK divider, per-transfer CPOL/CPHA
// Optional LSB-first ordering is enabled by SPI_MASTER_LSB_FIRST_EN.
module spi_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 3,
  parameter int CLK_DIV = 2
) (
  input logic               clk,
  input logic               reset,
  spi_master_ctrl_if.master bus
);
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int DIV_W  = $clog2(CLK_DIV) + 1;
  localparam int EDGE_W = $clog2(2 * DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic [CS_W-1:0]     sel_q, sel_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;
  logic                lsb_in;
  logic                lsb_q;
  logic                period_end;
  logic                last_edge;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = bus.lsb_first;
  always_ff @(posedge clk) begin
    if (reset)       lsb_q <= 1'b0;
    else if (accept) lsb_q <= bus.lsb_first;
  end
`else
  assign lsb_in = 1'b0;
  assign lsb_q  = 1'b0;
`endif

  function automatic logic head(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] drop(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // LSB-first receive shifts in from the top so rx_data keeps natural weights.
  function automatic logic [DATA_W-1:0] push(input logic [DATA_W-1:0] w, input logic b,
                                             input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign period_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_edge  = (edge_q == EDGE_W'(2 * DATA_W - 1));

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sel_d     = sel_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        sclk_d = bus.cpol;
        mosi_d = 1'b0;
        // The done cycle refuses a new start so cs_n stays high for two cycles.
        if (bus.start && !done_q && (int'(bus.cs_sel) < NUM_CS)) begin
          accept  = 1'b1;
          state_d = SETUP;
          div_d   = '0;
          edge_d  = '0;
          sel_d   = bus.cs_sel;
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          rx_sr_d = '0;
          if (!bus.cpha) begin
            mosi_d = head(bus.tx_data, lsb_in);
            tx_d   = drop(bus.tx_data, lsb_in);
          end else begin
            tx_d   = bus.tx_data;
          end
        end
      end
      SETUP: begin
        div_d = div_q + DIV_W'(1);
        if (period_end) begin
          div_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        div_d = div_q + DIV_W'(1);
        if (period_end) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          if (edge_q[0] == cpha_q) begin
            rx_sr_d = push(rx_sr_q, bus.miso, lsb_q);
          end else if (!last_edge) begin
            mosi_d = head(tx_q, lsb_q);
            tx_d   = drop(tx_q, lsb_q);
          end
          if (last_edge) state_d = HOLD;
        end
      end
      HOLD: begin
        div_d = div_q + DIV_W'(1);
        if (period_end) begin
          div_d     = '0;
          state_d   = IDLE;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          sclk_d    = cpol_q;
          mosi_d    = 1'b0;
        end
      end
    endcase
    busy_d = (state_d != IDLE);
    cs_n_d = '1;
    if (busy_d) cs_n_d[sel_d] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      tx_q      <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      sel_q     <= '0;
      cs_n_q    <= '1;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      tx_q      <= tx_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sel_q     <= sel_d;
      cs_n_q    <= cs_n_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;
  logic clk;
  logic reset;

  spi_master_ctrl_if #(.DATA_W(8), .NUM_CS(3)) bus ();

  spi_master_ctrl #(.DATA_W(8), .NUM_CS(3), .CLK_DIV(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  int          cyc_done;
  int          n_done;
  int          cs_bad;
  int          mosi_bad;
  int          rise_cnt;
  int          busy_seen;
  int          d1;
  int          d2;
  logic [7:0]  mosi_rx;
  logic [7:0]  slave_sr;
  logic        loop_en;
  logic [2:0]  exp_cs;
  logic [2:0]  cs_at_done;
  logic [2:0]  cs_a;
  logic [2:0]  cs_b;
  logic        busy_at_done;

  always_comb bus.miso = loop_en ? bus.mosi : slave_sr[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a transfer in the current cycle (cycle 0) and observes cycles 1..ncyc.
  task automatic run_xfer(input logic [7:0] tx, input logic [1:0] sel, input logic pol,
                          input logic pha, input int restart_at, input int ncyc);
    logic prev_sclk;
    logic prev_mosi;
    n_done = 0; cyc_done = -1; cs_bad = 0; mosi_bad = 0; rise_cnt = 0; mosi_rx = '0;
    cs_at_done = 'x; busy_at_done = 1'bx;
    exp_cs = 3'b111;
    exp_cs[sel] = 1'b0;
    bus.tx_data = tx; bus.cs_sel = sel; bus.cpol = pol; bus.cpha = pha; bus.start = 1'b1;
    prev_sclk = bus.sclk;
    prev_mosi = bus.mosi;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == restart_at + 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        n_done++;
        if (cyc_done < 0) begin
          cyc_done = c; cs_at_done = bus.cs_n; busy_at_done = bus.busy;
        end
      end
      if (cyc_done < 0 && (bus.cs_n !== exp_cs || bus.busy !== 1'b1)) cs_bad++;
      if (c > 1 && bus.busy === 1'b1 && bus.mosi !== prev_mosi &&
          !(bus.sclk !== prev_sclk && bus.sclk === (pha ? ~pol : pol))) mosi_bad++;
      if (prev_sclk === 1'b0 && bus.sclk === 1'b1) begin
        rise_cnt++;
        mosi_rx  = {mosi_rx[6:0], bus.mosi};
        slave_sr = slave_sr << 1;
      end
      if (c == restart_at) begin
        bus.start = 1'b1; bus.tx_data = ~tx; bus.cpol = ~pol;
      end
      prev_sclk = bus.sclk;
      prev_mosi = bus.mosi;
      step();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; loop_en = 1'b1; slave_sr = '0;
    bus.start = 1'b0; bus.tx_data = '0; bus.cs_sel = '0; bus.cpol = 1'b0; bus.cpha = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    bus.lsb_first = 1'b0;
`endif
    repeat (3) step();
    check("rst_sclk", 32'(bus.sclk), 0);
    check("rst_mosi", 32'(bus.mosi), 0);
    check("rst_cs_n", 32'(bus.cs_n), 32'h7);
    check("rst_rx", 32'(bus.rx_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    reset = 1'b0;
    step();

    // Mode 0 loopback, slave 0.
    run_xfer(8'hA5, 2'd0, 1'b0, 1'b0, -1, 45);
    check("m0_done_cyc", 32'(cyc_done), 37);
    check("m0_n_done", 32'(n_done), 1);
    check("m0_cs_busy", 32'(cs_bad), 0);
    check("m0_cs_done", 32'(cs_at_done), 32'h7);
    check("m0_busy_done", 32'(busy_at_done), 0);
    check("m0_rx", 32'(bus.rx_data), 32'hA5);
    check("m0_mosi_rx", 32'(mosi_rx), 32'hA5);
    check("m0_mosi_edges", 32'(mosi_bad), 0);
    check("m0_rises", 32'(rise_cnt), 8);
    repeat (5) step();
    check("m0_rx_stable", 32'(bus.rx_data), 32'hA5);

    // Mode 3, slave returns 0x3C on slave 2.
    bus.cpol = 1'b1;
    repeat (2) step();
    check("m3_idle_sclk", 32'(bus.sclk), 1);
    loop_en = 1'b0; slave_sr = 8'h3C;
    run_xfer(8'hC3, 2'd2, 1'b1, 1'b1, -1, 45);
    check("m3_done_cyc", 32'(cyc_done), 37);
    check("m3_cs_busy", 32'(cs_bad), 0);
    check("m3_rx", 32'(bus.rx_data), 32'h3C);
    check("m3_rises", 32'(rise_cnt), 8);
    check("m3_mosi_edges", 32'(mosi_bad), 0);
    check("m3_mosi_rx", 32'(mosi_rx), 32'hC3);
    check("m3_sclk_after", 32'(bus.sclk), 1);
    loop_en = 1'b1; bus.cpol = 1'b0;
    repeat (2) step();

    // Out-of-range chip select is ignored.
    busy_seen = 0; cs_bad = 0; n_done = 0;
    bus.cs_sel = 2'd3; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy !== 1'b0) busy_seen++;
      if (bus.cs_n !== 3'b111) cs_bad++;
      if (bus.done !== 1'b0) n_done++;
      step();
    end
    check("bad_sel_busy", 32'(busy_seen), 0);
    check("bad_sel_cs", 32'(cs_bad), 0);
    check("bad_sel_done", 32'(n_done), 0);

    // Mode 1 loopback with a second start and changed inputs at cycle 10.
    run_xfer(8'h5A, 2'd1, 1'b0, 1'b1, 10, 60);
    check("m1_n_done", 32'(n_done), 1);
    check("m1_done_cyc", 32'(cyc_done), 37);
    check("m1_cs_busy", 32'(cs_bad), 0);
    check("m1_rx", 32'(bus.rx_data), 32'h5A);
    check("m1_mosi_edges", 32'(mosi_bad), 0);
    bus.cpol = 1'b0;
    repeat (2) step();

    // Back-to-back with start held high through the done cycle.
    d1 = -1; d2 = -1; cs_a = 'x; cs_b = 'x;
    bus.tx_data = 8'h3C; bus.cs_sel = 2'd1; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.start = 1'b1;
    step();
    for (int c = 1; c <= 80; c++) begin
      if (bus.done === 1'b1) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (d1 > 0 && c == d1 + 1) cs_a = bus.cs_n;
      if (d1 > 0 && c == d1 + 2) begin
        cs_b = bus.cs_n; bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
    check("b2b_done1", 32'(d1), 37);
    check("b2b_gap_cs", 32'(cs_a), 32'h7);
    check("b2b_restart_cs", 32'(cs_b), 32'h5);
    check("b2b_done2", 32'(d2), 75);
    check("b2b_rx", 32'(bus.rx_data), 32'h3C);

    // Reset at cycle 20 of a mode 2 transfer.
    run_xfer(8'h77, 2'd2, 1'b1, 1'b0, -1, 19);
    reset = 1'b1;
    step();
    check("mid_rst_cs", 32'(bus.cs_n), 32'h7);
    check("mid_rst_sclk", 32'(bus.sclk), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_rx", 32'(bus.rx_data), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done !== 1'b0) n_done++;
      step();
    end
    check("mid_rst_no_done", 32'(n_done), 0);
    bus.cpol = 1'b0;
    repeat (2) step();

`ifdef SPI_MASTER_LSB_FIRST_EN
    bus.lsb_first = 1'b1;
    run_xfer(8'h01, 2'd0, 1'b0, 1'b0, -1, 45);
    check("lsb_rx", 32'(bus.rx_data), 32'h01);
    check("lsb_mosi_rx", 32'(mosi_rx), 32'h80);
    check("lsb_done_cyc", 32'(cyc_done), 37);
    bus.lsb_first = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Parametrised SPI master controller with a start/busy/done handshake toward the host logic. It generates SCLK from the system clock through a fixed divider and supports all four CPOL/CPHA modes, selected per transfer. It drives one of NUM_CS active-low chip selects and performs a full-duplex DATA_W-bit exchange. It replaces the fixed 8-bit, 3-slave master as the SPI endpoint between host-side control logic and off-chip slaves.

## Interface
- DATA_W, 8, transfer length in bits (≥2)
- NUM_CS, 3, number of chip-select outputs (≥1)
- CLK_DIV, 2, clk cycles per SCLK half-period (≥1)
- CS_W (localparam), max(1, $clog2(NUM_CS)), chip-select index width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  transfer request, accepted only in IDLE
- tx_data  in  DATA_W  word to send, captured on accept
- cs_sel  in  CS_W  slave index, captured on accept
- cpol  in  1  SCLK idle level, captured on accept
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; captured on accept
- miso  in  1  serial data from slave
- sclk  out  1  serial clock
- mosi  out  1  serial data to slave
- cs_n  out  NUM_CS  active-low chip selects, one-hot-low during a transfer
- rx_data  out  DATA_W  last completed received word
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse at transfer completion

## Operation
- Reset values: sclk=0, mosi=0, cs_n=all ones, rx_data=0, busy=0, done=0, state=IDLE.
- FSM states: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE: sclk follows registered cpol input; mosi=0.
  - start=1 with cs_sel<NUM_CS: capture tx_data, cs_sel, cpol, cpha; go to SETUP.
  - start=1 with cs_sel≥NUM_CS: ignored; stays IDLE, no busy, no done.
- SETUP (CLK_DIV cycles): cs_n[cs_sel]=0, sclk=cpol, busy=1. If cpha=0, mosi = first bit.
- XFER: 2·DATA_W SCLK edges, one edge every CLK_DIV cycles. Edge k (k=0..2·DATA_W−1) is leading for even k, trailing for odd k.
  - cpha=0: leading edge samples miso into the rx shift register; trailing edge (except the last) drives the next tx bit.
  - cpha=1: leading edge drives the next tx bit (first bit on k=0); trailing edge samples miso.
  - Sampling captures miso on the same clk edge that toggles sclk.
- HOLD (CLK_DIV cycles): sclk=cpol, cs_n still asserted, mosi held.
- Completion cycle: cs_n all high, rx_data ← shift register, done=1 for exactly one cycle, busy=0, return to IDLE.
- Bit order: MSB first (see Configuration).
- start while busy: ignored, never queued. Input changes during a transfer have no effect; captured copies are used.
- reset mid-transfer: all outputs return to reset values on the next clock; no done pulse; rx_data cleared.

## Timing
- Accept at cycle 0 (start high in IDLE). First busy/cs_n-low cycle is 1.
- done and cs_n deassertion occur at cycle 1 + CLK_DIV·(2·DATA_W + 2).
- The next start can be accepted in the cycle after done.
- Minimum cs_n-high gap between back-to-back transfers: 2 cycles.
- SCLK period is 2·CLK_DIV clk cycles, 50% duty.
- rx_data is stable from the done cycle until the next completion or reset.

## Configuration
- SPI_MASTER_LSB_FIRST_EN defined:
  - adds input port lsb_first (1 bit), captured on accept.
  - lsb_first=1 shifts tx bit 0 out first; received bits are placed LSB-first so rx_data keeps natural bit weights.
- Not defined: port absent, MSB-first only.

## Test plan
- DATA_W=8, CLK_DIV=2, mode 0, cs_sel=0, tx_data=0xA5, miso looped to mosi → rx_data=0xA5; done at cycle 37; only cs_n[0] low during cycles 1–36.
- Mode 3 (cpol=1, cpha=1), slave returns 0x3C, tx_data=0xC3 → sclk idles high; mosi transitions on falling edges; rx_data=0x3C; 8 rising sample edges.
- cs_sel=3 with NUM_CS=3 and start=1 → busy stays 0, cs_n=3'b111, no done.
- start pulsed again at cycle 10 of an active transfer → ignored; exactly one done at cycle 37.
- reset asserted at cycle 20 mid-transfer → next cycle cs_n=all ones, sclk=0, busy=0, rx_data=0, no done.
- With SPI_MASTER_LSB_FIRST_EN, lsb_first=1, tx_data=0x01, loopback → mosi high on first bit only; rx_data=0x01.
